// File: rtl/ddr_cmd_arbiter.sv
// DDR command arbiter: collects one pending command per bank, enforces
// inter-command timing with saturating down-counters, grants at most one
// bank per cycle in round-robin order and registers the winner onto the
// DDR command/address bus.
module ddr_cmd_arbiter #(
    parameter int NUM_BANKS = 8,
    parameter int ADDR_BITS = 14,
    parameter int BA_BITS   = 3,
    parameter int T_RCD     = 3,
    parameter int T_RP      = 3,
    parameter int T_WR      = 4,
    parameter int T_RRD     = 2,
    parameter int T_CCD     = 2,
    parameter int CNT_W     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_BANKS-1:0]           bank_req,
    input  logic [2*NUM_BANKS-1:0]         bank_cmd,
    input  logic [NUM_BANKS*ADDR_BITS-1:0] bank_addr,
    output logic [NUM_BANKS-1:0]           bank_stall,
    output logic                           cmd_valid,
    output logic                           ddr_cs_n,
    output logic                           ddr_ras_n,
    output logic                           ddr_cas_n,
    output logic                           ddr_we_n,
    output logic [BA_BITS-1:0]             ddr_ba,
    output logic [ADDR_BITS-1:0]           ddr_addr
);

    typedef enum logic [1:0] {
        CMD_PRE = 2'b00,
        CMD_ACT = 2'b01,
        CMD_RD  = 2'b10,
        CMD_WR  = 2'b11
    } cmd_e;

    // A grant at cycle t loads T-1 so the dependent command is eligible at t+T.
    localparam logic [CNT_W-1:0]   RCD_LD    = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0]   RP_LD     = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0]   WR_LD     = CNT_W'(T_WR - 1);
    localparam logic [CNT_W-1:0]   RRD_LD    = CNT_W'(T_RRD - 1);
    localparam logic [CNT_W-1:0]   CCD_LD    = CNT_W'(T_CCD - 1);
    localparam logic [BA_BITS-1:0] LAST_BANK = BA_BITS'(NUM_BANKS - 1);

    // Timer state
    logic [CNT_W-1:0] rcd_q [NUM_BANKS];
    logic [CNT_W-1:0] rcd_d [NUM_BANKS];
    logic [CNT_W-1:0] rp_q  [NUM_BANKS];
    logic [CNT_W-1:0] rp_d  [NUM_BANKS];
    logic [CNT_W-1:0] wr_q  [NUM_BANKS];
    logic [CNT_W-1:0] wr_d  [NUM_BANKS];
    logic [CNT_W-1:0] rrd_q, rrd_d;
    logic [CNT_W-1:0] ccd_q, ccd_d;
    logic [BA_BITS-1:0] rr_ptr_q, rr_ptr_d;

    // Bus register state
    logic                 cmd_valid_q, cmd_valid_d;
    logic                 cs_n_q, cs_n_d;
    logic                 ras_n_q, ras_n_d;
    logic                 cas_n_q, cas_n_d;
    logic                 we_n_q, we_n_d;
    logic [BA_BITS-1:0]   ba_q, ba_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;

    // Arbitration signals
    logic [NUM_BANKS-1:0] elig;
    logic [NUM_BANKS-1:0] grant;
    logic                 grant_vld;
    logic [BA_BITS-1:0]   grant_idx;
    logic [BA_BITS-1:0]   scan_idx;
    cmd_e                 gnt_cmd;
    logic [ADDR_BITS-1:0] gnt_addr;

    // Per-bank eligibility from the pending command and the relevant timers.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        elig = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            case (cmd_e'(bank_cmd[2*i +: 2]))
                CMD_ACT: elig[i] = bank_req[i] && (rp_q[i] == '0) && (rrd_q == '0);
                CMD_RD,
                CMD_WR:  elig[i] = bank_req[i] && (rcd_q[i] == '0) && (ccd_q == '0);
                default: elig[i] = bank_req[i] && (wr_q[i] == '0);
            endcase
        end
    end

    // Round-robin scan from rr_ptr; first eligible bank wins, nothing during reset.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            scan_idx = BA_BITS'((int'(rr_ptr_q) + k) % NUM_BANKS);
            if (!rst && !grant_vld && elig[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // One-hot grant vector and the winning bank's command/address.
    always_comb begin
        grant    = '0;
        gnt_cmd  = CMD_PRE;
        gnt_addr = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (grant_vld && (grant_idx == BA_BITS'(i))) begin
                grant[i] = 1'b1;
                gnt_cmd  = cmd_e'(bank_cmd[2*i +: 2]);
                gnt_addr = bank_addr[i*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    assign bank_stall = ~grant;

    // Timer decrement with reload-on-grant priority, and round-robin pointer update.
    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            rcd_d[i] = (rcd_q[i] != '0) ? rcd_q[i] - 1'b1 : '0;
            rp_d[i]  = (rp_q[i]  != '0) ? rp_q[i]  - 1'b1 : '0;
            wr_d[i]  = (wr_q[i]  != '0) ? wr_q[i]  - 1'b1 : '0;
        end
        rrd_d    = (rrd_q != '0) ? rrd_q - 1'b1 : '0;
        ccd_d    = (ccd_q != '0) ? ccd_q - 1'b1 : '0;
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == LAST_BANK) ? '0 : grant_idx + 1'b1;
            case (gnt_cmd)
                CMD_ACT: begin
                    rcd_d[grant_idx] = RCD_LD;
                    rrd_d            = RRD_LD;
                end
                CMD_RD: begin
                    ccd_d = CCD_LD;
                end
                CMD_WR: begin
                    ccd_d           = CCD_LD;
                    wr_d[grant_idx] = WR_LD;
                end
                default: begin
                    rp_d[grant_idx] = RP_LD;
                end
            endcase
        end
    end

    // Next bus word: encoded winning command, or NOP with ba/addr held.
    always_comb begin
        cmd_valid_d = 1'b0;
        cs_n_d      = 1'b0;
        ras_n_d     = 1'b1;
        cas_n_d     = 1'b1;
        we_n_d      = 1'b1;
        ba_d        = ba_q;
        addr_d      = addr_q;
        if (grant_vld) begin
            cmd_valid_d = 1'b1;
            ba_d        = grant_idx;
            case (gnt_cmd)
                CMD_ACT: begin
                    ras_n_d = 1'b0;
                    addr_d  = gnt_addr;
                end
                CMD_RD: begin
                    cas_n_d = 1'b0;
                    addr_d  = gnt_addr;
                end
                CMD_WR: begin
                    cas_n_d = 1'b0;
                    we_n_d  = 1'b0;
                    addr_d  = gnt_addr;
                end
                default: begin
                    // addr[10]=0 selects single-bank precharge
                    ras_n_d = 1'b0;
                    we_n_d  = 1'b0;
                    addr_d  = '0;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the timer arrays are reset too; reset must discard in-flight timing, so they cannot be left unreset like a RAM.
            for (int i = 0; i < NUM_BANKS; i++) begin
                rcd_q[i] <= '0;
                rp_q[i]  <= '0;
                wr_q[i]  <= '0;
            end
            rrd_q       <= '0;
            ccd_q       <= '0;
            rr_ptr_q    <= '0;
            cmd_valid_q <= 1'b0;
            cs_n_q      <= 1'b1;
            ras_n_q     <= 1'b1;
            cas_n_q     <= 1'b1;
            we_n_q      <= 1'b1;
            ba_q        <= '0;
            addr_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the pre-edge value of its _d.
            for (int i = 0; i < NUM_BANKS; i++) begin
                rcd_q[i] <= rcd_d[i];
                rp_q[i]  <= rp_d[i];
                wr_q[i]  <= wr_d[i];
            end
            rrd_q       <= rrd_d;
            ccd_q       <= ccd_d;
            rr_ptr_q    <= rr_ptr_d;
            cmd_valid_q <= cmd_valid_d;
            cs_n_q      <= cs_n_d;
            ras_n_q     <= ras_n_d;
            cas_n_q     <= cas_n_d;
            we_n_q      <= we_n_d;
            ba_q        <= ba_d;
            addr_q      <= addr_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign ddr_cs_n  = cs_n_q;
    assign ddr_ras_n = ras_n_q;
    assign ddr_cas_n = cas_n_q;
    assign ddr_we_n  = we_n_q;
    assign ddr_ba    = ba_q;
    assign ddr_addr  = addr_q;

endmodule

// File: doc/ddr_cmd_arbiter.md
Name: ddr_cmd_arbiter

Overview:
- Sits directly downstream of the per-bank state machines.
- Collects one pending DRAM command request per bank (ACT/RD/WR/PRE plus row or column address), checks inter-command timing, and grants at most one bank per cycle in round-robin order.
- Drives each bank's stall input and registers the winning command onto the DDR command/address bus.

Parameters:
- NUM_BANKS, 8, number of bank state machines served
- ADDR_BITS, 14, row/column address width
- BA_BITS, 3, bank address width (log2 NUM_BANKS)
- T_RCD, 3, min cycles ACT -> RD/WR, same bank (>=1)
- T_RP, 3, min cycles PRE -> ACT, same bank (>=1)
- T_WR, 4, min cycles WR -> PRE, same bank (>=1)
- T_RRD, 2, min cycles ACT -> ACT, any banks (>=1)
- T_CCD, 2, min cycles RD/WR -> RD/WR, any banks (>=1)
- CNT_W, 4, timer width; must hold max(T_*)-1

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- bank_req  in  NUM_BANKS  bank i has a command pending (held until granted)
- bank_cmd  in  2*NUM_BANKS  per-bank slice [2i+1:2i]: 00 PRE, 01 ACT, 10 RD, 11 WR
- bank_addr  in  NUM_BANKS*ADDR_BITS  per-bank row (ACT) or column (RD/WR) address
- bank_stall  out  NUM_BANKS  1 = bank i not granted this cycle
- cmd_valid  out  1  a real command is on the bus this cycle
- ddr_cs_n  out  1  chip select
- ddr_ras_n  out  1  row address strobe
- ddr_cas_n  out  1  column address strobe
- ddr_we_n  out  1  write enable
- ddr_ba  out  BA_BITS  bank address
- ddr_addr  out  ADDR_BITS  address bus

Behaviour:
- Reset (rst=1 at an edge):
  - bus outputs become cs_n=1, ras_n=cas_n=we_n=1, ba=0, addr=0, cmd_valid=0;
  - all timers become 0;
  - rr_ptr becomes 0.
  - While rst=1, grant is forced 0 and bank_stall is all ones.
  - Reset mid-operation discards any in-flight timing; the arbiter has no other memory of it.
- Per-bank timers, down-counters saturating at 0:
  - rcd[i] for T_RCD
  - rp[i] for T_RP
  - wr[i] for T_WR
- Global timers, same behaviour: rrd for T_RRD, ccd for T_CCD.
- Timer load on grant at cycle t: the timer loads T_x-1, so the dependent command first becomes eligible at cycle t+T_x.
  - ACT grant loads rcd[i] and rrd.
  - RD grant loads ccd.
  - WR grant loads ccd and wr[i].
  - PRE grant loads rp[i].
- Eligibility (combinational), elig[i] = bank_req[i] and:
  - ACT: rp[i]==0 and rrd==0
  - RD/WR: rcd[i]==0 and ccd==0
  - PRE: wr[i]==0
- Arbitration (combinational, same cycle):
  - Scan eligible banks from rr_ptr upward, wrapping modulo NUM_BANKS; first hit wins; grant is one-hot or zero.
  - bank_stall = ~grant.
  - On a grant to bank g, rr_ptr <= (g+1) mod NUM_BANKS. Otherwise rr_ptr holds.
- Bus register (one-cycle latency): a grant at cycle t appears on the bus at t+1 with cmd_valid=1, ddr_ba=g and the encoding below.
  - ACT: ras/cas/we = 0/1/1, addr = bank_addr[g]
  - RD: 1/0/1, addr = column
  - WR: 1/0/0, addr = column
  - PRE: 0/1/0, addr = 0 (addr[10]=0, single-bank precharge)
- No grant: NOP is driven (cs_n=0, ras/cas/we = 1/1/1, ba and addr hold), cmd_valid=0.
- Requests are level-held. Deasserting bank_req without a grant is legal and causes no side effect.
- Simultaneous events:
  - A timer reload on grant takes priority over its decrement in the same cycle.
  - Timers belonging to different banks are independent.
- A bank whose request is ineligible is skipped; it does not block a lower-priority eligible bank.

Test Plan:
- Reset, then a single ACT on bank 2 with row 0x1A3 -> bank_stall[2]=0 same cycle; next cycle ras/cas/we=0/1/1, ba=2, addr=0x1A3, cmd_valid=1.
- ACT on bank 0 at t, then RD on bank 0 held -> stall[0]=1 at t+1 and t+2, granted at t+3 (T_RCD=3); RD appears on the bus at t+4.
- Banks 1, 3 and 5 all requesting RD with timers clear and rr_ptr=0 -> grants to 1, then 3, then 5, spaced T_CCD=2 apart; rr_ptr ends at 6.
- WR on bank 4 at t, then PRE on bank 4 -> PRE granted at t+4 (T_WR); an ACT on bank 4 afterwards granted no earlier than 3 cycles after the PRE grant.
- ACT on bank 0 at t and ACT pending on bank 1 -> bank 1 granted at t+2 (T_RRD); a concurrent RD on bank 6 with rcd clear is granted at t+1.
- Assert rst for one cycle mid-sequence while rcd and ccd are nonzero -> bus at deselect, cmd_valid=0; after reset a pending RD with no prior ACT is granted immediately (timers cleared).
